// File: rtl/uart_rx_ovs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_ovs
// Purpose  : Oversampling UART receiver. It runs on the system clock with an
//            internal oversample tick and takes a 3-sample majority per bit.
//            Data length, parity and stop bits are configurable. Received
//            words go out on a valid/ready interface with framing, parity
//            and overrun reporting.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int c_DIV = CLK_HZ / (BAUD * OVS);
    localparam int c_TW  = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam int c_SW  = $clog2(OVS);
    localparam int c_BW  = $clog2(DATA_BITS);

    localparam logic [c_TW-1:0] c_TMAX     = c_TW'(c_DIV - 1);
    localparam logic [c_SW-1:0] c_S_LO     = c_SW'(OVS/2 - 1);
    localparam logic [c_SW-1:0] c_S_MI     = c_SW'(OVS/2);
    localparam logic [c_SW-1:0] c_S_HI     = c_SW'(OVS/2 + 1);
    localparam logic [c_SW-1:0] c_S_END    = c_SW'(OVS - 1);
    localparam logic [c_BW-1:0] c_B_LAST   = c_BW'(DATA_BITS - 1);
    localparam logic            c_STOP_LST = (STOP_BITS == 2);
    localparam logic            c_PODD     = (PARITY_ODD != 0);
    localparam logic            c_PEN      = (PARITY_EN != 0);

    // Reject clock/baud combinations that leave fewer than two clocks per tick
    generate
        if (c_DIV < 2) begin : g_div_check
            $error("uart_rx_ovs: CLK_HZ/(BAUD*OVS) must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_rx_prev;
    logic [c_TW-1:0]        r_tcnt;
    logic [c_SW-1:0]        r_s;
    logic [1:0]             r_smp;
    logic [c_BW-1:0]        r_bcnt;
    logic                   r_scnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic [DATA_BITS-1:0]   r_dout;
    logic                   r_dout_valid;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;

    logic w_fall;
    logic w_start;
    logic w_tick;
    logic w_mid;
    logic w_end;
    logic w_maj;
    logic w_done;

    assign w_fall  = r_rx_prev & ~r_rx_s;
    assign w_start = (r_state == S_IDLE) && w_fall;
    assign w_tick  = (r_tcnt == c_TMAX);
    assign w_mid   = w_tick && (r_s == c_S_HI);
    assign w_end   = w_tick && (r_s == c_S_END);
    // Third sample is taken live from rx_s on the resolving tick
    assign w_maj   = (r_smp[0] & r_smp[1]) | ((r_smp[0] | r_smp[1]) & r_rx_s);

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Oversample tick divider; the start edge re-phases it to the start bit
    always_ff @(posedge clk) begin
        if (!rst || w_start || w_tick) r_tcnt <= '0;
        else                           r_tcnt <= r_tcnt + 1'b1;
    end

    // Sample position within the current bit and the two early vote samples
    always_ff @(posedge clk) begin
        if (!rst || w_start) begin
            r_s   <= '0;
            r_smp <= 2'b11;
        end else if (w_tick) begin
            r_s <= (r_s == c_S_END) ? '0 : r_s + 1'b1;
            if (r_s == c_S_LO) r_smp[0] <= r_rx_s;
            if (r_s == c_S_MI) r_smp[1] <= r_rx_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; a frame completes at the mid-bit vote of the last stop bit
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_nxt = S_START;
            S_START: begin
                if (w_mid && w_maj) w_state_nxt = S_IDLE;
                else if (w_end)     w_state_nxt = S_DATA;
            end
            S_DATA:   if (w_end && (r_bcnt == c_B_LAST))
                          w_state_nxt = c_PEN ? S_PARITY : S_STOP;
            S_PARITY: if (w_end) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_mid && (r_scnt == c_STOP_LST)) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: bit/stop counters, shift register, error accumulation
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_scnt  <= 1'b0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else if (w_start) begin
            r_bcnt <= '0;
            r_scnt <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (r_state == S_DATA) begin
                if (w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                if (w_end) r_bcnt  <= (r_bcnt == c_B_LAST) ? '0 : r_bcnt + 1'b1;
            end
            if ((r_state == S_PARITY) && w_mid)
                r_perr <= ((w_maj ^ (^r_shift)) != c_PODD);
            if (r_state == S_STOP) begin
                if (w_mid && !w_maj) r_ferr <= 1'b1;
                if (w_end)           r_scnt <= 1'b1;
            end
        end
    end

    // Output holding register: load when free or being drained, else flag overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done && (!r_dout_valid || dout_ready)) begin
                r_dout       <= r_shift;
                r_frame_err  <= r_ferr | ~w_maj;
                r_parity_err <= r_perr;
                r_dout_valid <= 1'b1;
            end else begin
                if (w_done) r_overrun <= 1'b1;
                if (r_dout_valid && dout_ready) r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Parametrised oversampling UART receiver, next generation of the team's serial receive path. It replaces the divided-clock, single-sample receiver.
- Runs entirely on the system clock with an internal oversample tick.
- Samples each bit three times with a majority vote.
- Supports configurable data length, parity and stop bits.
- Presents received bytes on a valid/ready interface with framing, parity and overrun error reporting.
- Sits between the board RX pin and the command/FIFO logic.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, line bit rate
OVS, 16, oversample ticks per bit (even, 8..32)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits checked (1 or 2)
Derived: DIV = CLK_HZ/(BAUD*OVS), integer division, must be >= 2. Elaboration error if DIV < 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
rx  in  1  asynchronous serial input, idle high
dout  out  DATA_BITS  received data, LSB = first bit on line
dout_valid  out  1  dout and error flags valid
dout_ready  in  1  consumer accepts word when dout_valid & dout_ready
busy  out  1  frame reception in progress
frame_err  out  1  stop-bit error for word in dout (qualified by dout_valid)
parity_err  out  1  parity mismatch for word in dout (qualified by dout_valid)
overrun  out  1  one-cycle pulse: frame completed while previous word unaccepted

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; sync flops = 1; tick counter = 0; dout = 0; dout_valid, busy, frame_err, parity_err, overrun = 0. Reset mid-frame abandons the frame; no output.
- Input: 2-flop synchroniser on rx, output rx_s. Edge detection uses rx_s and its previous value.
- Tick generator: counter 0..DIV-1, tick pulses one clk when counter = DIV-1.
  - Free-running in IDLE.
  - Cleared to 0 on the start-edge cycle, so tick phase aligns to the start bit.
- Sample counter s: 0..OVS-1, advances on tick. On each tick with s in {OVS/2-1, OVS/2, OVS/2+1}, record rx_s. The bit value is the 2-of-3 majority, resolved when s = OVS/2+1.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: busy=0. Falling edge on rx_s (1->0) -> START, s=0, busy=1 next cycle.
  - START: majority at mid-bit = 1 -> false start, back to IDLE, no output, no flags. Majority = 0 -> continue to end of bit (s = OVS-1 tick) -> DATA.
  - DATA: DATA_BITS bits, LSB first, shifted into a shift register. Bit counter wraps to 0 after the last bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: received bit XOR data reduction-XOR. perr = (xor != PARITY_ODD).
  - STOP: each stop majority must be 1, otherwise ferr=1. With 2 stop bits, an error in either sets ferr. The first stop bit runs full length. Frame ends at the mid-bit majority of the last stop bit, not the full bit, so back-to-back frames are tolerated.
  - At frame end: -> IDLE, busy=0 on the following cycle. A falling edge is accepted from that IDLE cycle onward.
- Delivery, on the clk after the final stop majority resolves:
  - If dout_valid=0, or dout_valid & dout_ready in the same cycle: load dout, frame_err, parity_err; dout_valid=1.
  - Else: drop the new frame, keep the old word and flags, pulse overrun for 1 cycle.
- Handshake:
  - dout_valid falls on the cycle after dout_valid & dout_ready unless a new word loads in the same cycle.
  - dout and the flags are stable while dout_valid=1 and not accepted.
- Errored frames (ferr or perr) are still delivered with their flags set. A break (rx held low) yields data 0, frame_err=1, then waits in IDLE for rx_s high->low.
- parity_err is always 0 when PARITY_EN=0.

Test Plan:
- Sim params CLK_HZ=1600000, BAUD=10000, OVS=16 (DIV=10, 160 clk/bit), 8N1, dout_ready=1. Send 0xA5 -> dout=0xA5, dout_valid one cycle after stop mid-sample, no flags; send 0x00 then 0xFF back-to-back -> both received in order.
- 8E1 (PARITY_EN=1): send 0x37 with correct parity 1 -> parity_err=0. Send 0x37 with parity 0 -> dout=0x37, parity_err=1.
- Stop bit forced 0 on 0x55 -> frame_err=1, dout=0x55. Hold rx low 20 bit times -> one word 0x00 with frame_err=1, no further words until rx returns high then falls.
- Glitch: rx low for 40 clk then high -> no dout_valid, busy returns 0. Single-sample 1-clk pulse inverted inside the data-bit majority window -> correct byte 0xC3 received.
- dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun pulses once at 0x22 completion. Then ready=1 -> 0x11 accepted, dout_valid=0.
- rst=0 asserted mid-data of 0x99 -> all outputs 0 next cycle. Release and send 0x3C -> dout=0x3C. Repeat with DATA_BITS=7, STOP_BITS=2 for 0x5A: second stop bit 0 -> frame_err=1.
